// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute control sequencer for the RISC datapath.
// Optional multiply/divide sequencing is enabled with `define CTRL_MULDIV_EN.
module control_sequencer #(
  parameter int IR_W        = 32,
  parameter int OPC_W       = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IR_W-1:0]  ir,
  input  logic             stop,
  input  logic             conff,
  input  logic             mem_ready,
`ifdef CTRL_MULDIV_EN
  input  logic             alu_done,
  output logic             hii,
  output logic             loi,
`endif
  output logic             pco,
  output logic             pci,
  output logic             pc_inc,
  output logic             iri,
  output logic             mari,
  output logic             mdri,
  output logic             mdro,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       gr_sel,
  output logic             rin,
  output logic             rout,
  output logic             baout,
  output logic             ryi,
  output logic             rzi,
  output logic             rzlo,
  output logic             csigno,
  output logic             con_in,
  output logic             ipo,
  output logic             opi,
  output logic             hio,
  output logic             loo,
  output logic [OPC_W-1:0] alu_op,
  output logic             run,
  output logic             fault,
  output logic             illegal
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_ROL  = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_ORI  = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(15);
  localparam logic [OPC_W-1:0] OP_DIV  = OPC_W'(16);
  localparam logic [OPC_W-1:0] OP_BR   = OPC_W'(18);
  localparam logic [OPC_W-1:0] OP_JR   = OPC_W'(19);
  localparam logic [OPC_W-1:0] OP_OUT  = OPC_W'(21);
  localparam logic [OPC_W-1:0] OP_IN   = OPC_W'(22);
  localparam logic [OPC_W-1:0] OP_MFHI = OPC_W'(23);
  localparam logic [OPC_W-1:0] OP_MFLO = OPC_W'(24);
  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(25);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(26);

  localparam logic [1:0] GR_RA = 2'b01;
  localparam logic [1:0] GR_RB = 2'b10;
  localparam logic [1:0] GR_RC = 2'b11;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH0, S_FETCH1, S_FETCH2, S_T3, S_T4, S_T5, S_T6, S_T7, S_STOPPED, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_JR, C_IN, C_OUT,
    C_MFHI, C_MFLO, C_NOP, C_HALT, C_MULDIV, C_BAD
  } class_e;

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             fault_reg, fault_next;

  logic [OPC_W-1:0] opc;
  class_e           op_class;
  logic             wait_active;
  logic             wait_ready;
  logic             ir_operands_unused;

  assign opc = ir[IR_W-1 -: OPC_W];
  // Operand fields belong to the datapath; only the opcode steers sequencing.
  assign ir_operands_unused = ^ir[IR_W-OPC_W-1:0];

  always_comb begin
    op_class = C_BAD;
    if (opc >= OP_ADD && opc <= OP_ROL)       op_class = C_ALU;
    else if (opc >= OP_ADDI && opc <= OP_ORI) op_class = C_IMM;
    else if (opc == OP_LDI)                   op_class = C_LDI;
    else if (opc == OP_LD)                    op_class = C_LD;
    else if (opc == OP_ST)                    op_class = C_ST;
    else if (opc == OP_BR)                    op_class = C_BR;
    else if (opc == OP_JR)                    op_class = C_JR;
    else if (opc == OP_IN)                    op_class = C_IN;
    else if (opc == OP_OUT)                   op_class = C_OUT;
    else if (opc == OP_MFHI)                  op_class = C_MFHI;
    else if (opc == OP_MFLO)                  op_class = C_MFLO;
    else if (opc == OP_NOP)                   op_class = C_NOP;
    else if (opc == OP_HALT)                  op_class = C_HALT;
`ifdef CTRL_MULDIV_EN
    else if (opc == OP_MUL || opc == OP_DIV)  op_class = C_MULDIV;
`else
    else if (opc == OP_MUL || opc == OP_DIV)  op_class = C_BAD;
`endif
  end

  // Steps that stall on an external handshake, all bounded by one timeout counter.
  always_comb begin
    wait_active = 1'b0;
    wait_ready  = mem_ready;
    case (state_reg)
      S_FETCH1: wait_active = 1'b1;
      S_T4: begin
        if (op_class == C_MULDIV) begin
          wait_active = 1'b1;
`ifdef CTRL_MULDIV_EN
          wait_ready  = alu_done;
`endif
        end
      end
      S_T6:    wait_active = (op_class == C_LD);
      S_T7:    wait_active = (op_class == C_ST);
      default: wait_active = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= S_RESET;
      cnt_reg   <= '0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      fault_reg <= fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    fault_next = fault_reg;
    case (state_reg)
      S_RESET:   state_next = S_FETCH0;
      S_FETCH0:  state_next = stop ? S_STOPPED : S_FETCH1;
      S_STOPPED: if (!stop) state_next = S_FETCH0;
      S_FETCH1:  if (mem_ready) state_next = S_FETCH2;
      S_FETCH2:  state_next = S_T3;
      S_T3: begin
        case (op_class)
          C_HALT:                                           state_next = S_HALT;
          C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_BAD:  state_next = S_FETCH0;
          default:                                          state_next = S_T4;
        endcase
      end
      S_T4: if (!wait_active || wait_ready) state_next = S_T5;
      S_T5: begin
        case (op_class)
          C_ALU, C_IMM, C_LDI: state_next = S_FETCH0;
          default:             state_next = S_T6;
        endcase
      end
      S_T6: begin
        if (op_class == C_LD || op_class == C_ST) begin
          if (!wait_active || wait_ready) state_next = S_T7;
        end else begin
          state_next = S_FETCH0;
        end
      end
      S_T7:   if (!wait_active || wait_ready) state_next = S_FETCH0;
      S_HALT: state_next = S_HALT;
      default: state_next = S_RESET;
    endcase

    // Count only cycles without the handshake; the entry cycle may already complete.
    if (wait_active && !wait_ready) begin
      if (cnt_reg == TIMEOUT_LAST) begin
        state_next = S_HALT;
        fault_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    pco = 1'b0; pci = 1'b0; pc_inc = 1'b0; iri = 1'b0; mari = 1'b0;
    mdri = 1'b0; mdro = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    gr_sel = 2'b00; rin = 1'b0; rout = 1'b0; baout = 1'b0;
    ryi = 1'b0; rzi = 1'b0; rzlo = 1'b0; csigno = 1'b0; con_in = 1'b0;
    ipo = 1'b0; opi = 1'b0; hio = 1'b0; loo = 1'b0;
    illegal = 1'b0;
    alu_op  = OP_ADD;
    run     = !(state_reg == S_RESET || state_reg == S_STOPPED || state_reg == S_HALT);
    fault   = fault_reg;
`ifdef CTRL_MULDIV_EN
    hii = 1'b0;
    loi = 1'b0;
`endif
    case (state_reg)
      S_FETCH0: begin pco = 1'b1; mari = 1'b1; pc_inc = 1'b1; end
      // MDR loads every wait cycle so the word present on the ready cycle is the one kept.
      S_FETCH1: begin mem_read = 1'b1; mdri = 1'b1; end
      S_FETCH2: begin mdro = 1'b1; iri = 1'b1; end
      S_T3: begin
        case (op_class)
          C_ALU, C_IMM:      begin gr_sel = GR_RB; rout = 1'b1; ryi = 1'b1; end
          C_LDI, C_LD, C_ST: begin gr_sel = GR_RB; baout = 1'b1; ryi = 1'b1; end
          C_BR:              begin gr_sel = GR_RA; rout = 1'b1; con_in = 1'b1; end
          C_JR:              begin gr_sel = GR_RA; rout = 1'b1; pci = 1'b1; end
          C_IN:              begin ipo = 1'b1; gr_sel = GR_RA; rin = 1'b1; end
          C_OUT:             begin gr_sel = GR_RA; rout = 1'b1; opi = 1'b1; end
          C_MFHI:            begin hio = 1'b1; gr_sel = GR_RA; rin = 1'b1; end
          C_MFLO:            begin loo = 1'b1; gr_sel = GR_RA; rin = 1'b1; end
          C_MULDIV:          begin gr_sel = GR_RA; rout = 1'b1; ryi = 1'b1; end
          C_BAD:             illegal = 1'b1;
          default:           ;
        endcase
      end
      S_T4: begin
        case (op_class)
          C_ALU:             begin gr_sel = GR_RC; rout = 1'b1; rzi = 1'b1; alu_op = opc; end
          C_IMM:             begin csigno = 1'b1; rzi = 1'b1; alu_op = opc; end
          C_LDI, C_LD, C_ST: begin csigno = 1'b1; rzi = 1'b1; end
          C_BR:              begin pco = 1'b1; ryi = 1'b1; end
          C_MULDIV:          begin gr_sel = GR_RB; rout = 1'b1; rzi = 1'b1; alu_op = opc; end
          default:           ;
        endcase
      end
      S_T5: begin
        case (op_class)
          C_ALU, C_IMM, C_LDI: begin rzlo = 1'b1; gr_sel = GR_RA; rin = 1'b1; end
          C_LD, C_ST:          begin rzlo = 1'b1; mari = 1'b1; end
          C_BR:                begin csigno = 1'b1; rzi = 1'b1; end
          C_MULDIV: begin
            rzlo = 1'b1;
`ifdef CTRL_MULDIV_EN
            loi  = 1'b1;
`endif
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (op_class)
          C_LD: begin mem_read = 1'b1; mdri = 1'b1; end
          C_ST: begin gr_sel = GR_RA; rout = 1'b1; mdri = 1'b1; end
          C_BR: begin rzlo = conff; pci = conff; end
`ifdef CTRL_MULDIV_EN
          C_MULDIV: hii = 1'b1;
`endif
          default: ;
        endcase
      end
      S_T7: begin
        case (op_class)
          C_LD:    begin mdro = 1'b1; gr_sel = GR_RA; rin = 1'b1; end
          C_ST:    begin mdro = 1'b1; mem_write = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
